// File: rtl/qep_pkg.sv
// qep_pkg: shared types and constants for the QEP glitch-filter limit sequencer.
// Holds the sequencer state encoding, channel indices and the default limit width.
// Helper functions clamp degenerate cycle-count parameters and size counters.
package qep_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    APPLY   = 2'd2,
    FLUSH   = 2'd3
  } qep_state_t;

  // Channel indices into the 3-line raw/edge vectors
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_I   = 2;
  localparam int NUM_CH = 3;

  // Default width of each filter limit
  localparam int QEP_COUNTER_WIDTH = 32;

  // A cycle count of zero behaves like one cycle.
  function automatic int clamp_min1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qep_quiet_detect.sv
// qep_quiet_detect: edge detection on the three raw encoder lines plus the quiet counter.
// Latency: edges are combinational against the previous-cycle line values; quiet_reached is combinational.
// Backpressure: none; runs every cycle, the quiet counter only advances while run is high.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   raw[2:0]       synchronised raw lines, indexed by CH_A/CH_B/CH_I
//   run            high while the sequencer is waiting for quiet; low holds the counter at 0
//   edges[2:0]     per-line edge this cycle (raw != previous raw)
//   any_edge       OR of edges
//   quiet_reached  QUIET_CYCLES consecutive edge-free cycles completed this cycle
module qep_quiet_detect
  import qep_pkg::*;
#(
  parameter int QUIET_CYCLES = 16,
  parameter int CNT_W        = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] raw,
  input  logic              run,
  output logic [NUM_CH-1:0] edges,
  output logic              any_edge,
  output logic              quiet_reached
);

  localparam int              QEFF  = clamp_min1(QUIET_CYCLES);
  localparam logic [CNT_W-1:0] QLAST = CNT_W'(QEFF - 1);

  logic [NUM_CH-1:0] raw_z1;
  logic [CNT_W-1:0]  quiet_cnt;

  // raw_z1 resets to 0, so a line that is high out of reset shows as an edge
  // in the first cycle.
  assign edges         = raw ^ raw_z1;
  assign any_edge      = |edges;
  assign quiet_reached = run && !any_edge && (quiet_cnt == QLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_z1    <= '0;
      quiet_cnt <= '0;
    end else begin
      raw_z1 <= raw;
      if (!run || any_edge) begin
        quiet_cnt <= '0;
      end else if (quiet_cnt != QLAST) begin
        // Holding at QLAST keeps the counter from wrapping; the sequencer
        // leaves the wait state as soon as it gets there anyway.
        quiet_cnt <= quiet_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/qep_filter_sched.sv
// qep_filter_sched: sequences atomic limit updates for the QEP A/B/Index glitch filters.
// Latency: forced write -> limits at T+2, done at T+2+FLUSH_CYCLES; quiet write waits QUIET_CYCLES (bounded by TIMEOUT_CYCLES).
// Backpressure: cfg_ready is low for the whole sequence; an offered set is held off, never dropped.
//
// Optional feature macro: QEP_FILTER_STATS_EN (adds saturating per-line edge counters
// edge_cnt_a/b/i, cleared in the APPLY cycle).
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cfg_valid/cfg_ready      limit-set handshake; cfg_force and cfg_lim_* sampled with it
//   cfg_force                skip the quiet wait and apply immediately
//   cfg_lim_a/b/i            new limits for channels A, B, Index
//   raw_a/b/i                synchronised, unfiltered encoder lines
//   lim_a/b/i                registered limits to the filters (only change APPLY->FLUSH)
//   flt_rst                  registered reset to the filter instances, high during FLUSH
//   busy                     high whenever the sequencer is not idle
//   apply_done               one-cycle pulse in the first idle cycle after a sequence
//   timeout_err              one-cycle pulse in the wait cycle where the timeout expired
module qep_filter_sched
  import qep_pkg::*;
#(
  parameter int                     COUNTER_WIDTH  = QEP_COUNTER_WIDTH,
  parameter logic [COUNTER_WIDTH-1:0] DEFAULT_LIM  = '0,
  parameter int                     QUIET_CYCLES   = 16,
  parameter int                     TIMEOUT_CYCLES = 65536,
  parameter int                     FLUSH_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic                     cfg_force,
  input  logic [COUNTER_WIDTH-1:0] cfg_lim_a,
  input  logic [COUNTER_WIDTH-1:0] cfg_lim_b,
  input  logic [COUNTER_WIDTH-1:0] cfg_lim_i,
  input  logic                     raw_a,
  input  logic                     raw_b,
  input  logic                     raw_i,
  output logic [COUNTER_WIDTH-1:0] lim_a,
  output logic [COUNTER_WIDTH-1:0] lim_b,
  output logic [COUNTER_WIDTH-1:0] lim_i,
  output logic                     flt_rst,
  output logic                     busy,
  output logic                     apply_done,
  output logic                     timeout_err
`ifdef QEP_FILTER_STATS_EN
  ,
  output logic [15:0]              edge_cnt_a,
  output logic [15:0]              edge_cnt_b,
  output logic [15:0]              edge_cnt_i
`endif
);

  localparam int QEFF    = clamp_min1(QUIET_CYCLES);
  localparam int TEFF    = clamp_min1(TIMEOUT_CYCLES);
  localparam int FEFF    = clamp_min1(FLUSH_CYCLES);
  // One counter serves both the timeout (QUIESCE) and the flush length (FLUSH),
  // so it is sized for the largest terminal value.
  localparam int CNT_MAX = max3(QEFF, TEFF, FEFF);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TLAST = CNT_W'(TEFF - 1);
  localparam logic [CNT_W-1:0] FLAST = CNT_W'(FEFF - 1);

  qep_state_t state, state_nxt;

  logic [CNT_W-1:0]         seq_cnt;
  logic [COUNTER_WIDTH-1:0] shadow_a, shadow_b, shadow_i;
  logic [NUM_CH-1:0]        raw_vec;
  logic [NUM_CH-1:0]        edges;
  logic                     any_edge;
  logic                     quiet_reached;
  logic                     quiet_run;
  logic                     handshake;
  logic                     timeout_hit;

  assign raw_vec[CH_A] = raw_a;
  assign raw_vec[CH_B] = raw_b;
  assign raw_vec[CH_I] = raw_i;

  qep_quiet_detect #(
    .QUIET_CYCLES (QUIET_CYCLES),
    .CNT_W        (CNT_W)
  ) u_quiet (
    .clk           (clk),
    .rst_n         (rst_n),
    .raw           (raw_vec),
    .run           (quiet_run),
    .edges         (edges),
    .any_edge      (any_edge),
    .quiet_reached (quiet_reached)
  );

  // Next-state and Moore-style outputs (all derived from registered state).
  always_comb begin
    state_nxt   = state;
    cfg_ready   = 1'b0;
    busy        = 1'b1;
    quiet_run   = 1'b0;
    timeout_hit = 1'b0;
    timeout_err = 1'b0;
    handshake   = 1'b0;

    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        handshake = cfg_valid;
        if (cfg_valid) begin
          state_nxt = cfg_force ? APPLY : QUIESCE;
        end
      end
      QUIESCE: begin
        quiet_run   = 1'b1;
        timeout_hit = (seq_cnt == TLAST);
        timeout_err = timeout_hit;
        // Timeout takes priority so timeout_err is reported even when quiet
        // is reached in the same cycle.
        if (timeout_hit || quiet_reached) begin
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        state_nxt = FLUSH;
      end
      FLUSH: begin
        if (seq_cnt == FLAST) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sequence counter: counts wait cycles in QUIESCE and flush cycles in FLUSH,
  // cleared on every state change so each phase starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt <= '0;
    end else begin
      case (state)
        QUIESCE, FLUSH: seq_cnt <= (state_nxt == state) ? seq_cnt + CNT_W'(1) : '0;
        default:        seq_cnt <= '0;
      endcase
    end
  end

  // Shadow limits are captured on the handshake and only reach the filters
  // at the end of APPLY, so all three channels switch in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_a <= DEFAULT_LIM;
      shadow_b <= DEFAULT_LIM;
      shadow_i <= DEFAULT_LIM;
    end else if (handshake) begin
      shadow_a <= cfg_lim_a;
      shadow_b <= cfg_lim_b;
      shadow_i <= cfg_lim_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lim_a <= DEFAULT_LIM;
      lim_b <= DEFAULT_LIM;
      lim_i <= DEFAULT_LIM;
    end else if (state == APPLY) begin
      lim_a <= shadow_a;
      lim_b <= shadow_b;
      lim_i <= shadow_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_rst    <= 1'b0;
      apply_done <= 1'b0;
    end else begin
      flt_rst    <= (state_nxt == FLUSH);
      apply_done <= (state == FLUSH) && (state_nxt == IDLE);
    end
  end

`ifdef QEP_FILTER_STATS_EN
  logic [15:0] stat_cnt [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        stat_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (state == APPLY) begin
          stat_cnt[c] <= '0;
        end else if (edges[c] && (stat_cnt[c] != 16'hFFFF)) begin
          stat_cnt[c] <= stat_cnt[c] + 16'd1;
        end
      end
    end
  end

  assign edge_cnt_a = stat_cnt[CH_A];
  assign edge_cnt_b = stat_cnt[CH_B];
  assign edge_cnt_i = stat_cnt[CH_I];
`else
  // Per-line edges are only consumed by the statistics counters.
  logic unused_edges;
  assign unused_edges = ^edges;
`endif

endmodule

// File: tb/tb_qep_filter_sched.sv
// tb_qep_filter_sched: self-checking bench for qep_filter_sched.
// Each write is predicted from the raw-line pattern: the apply cycle is the first point with
// QUIET consecutive edge-free wait cycles, or the timeout cycle, and every output is checked per cycle.
module tb_qep_filter_sched;

  localparam int          CW    = 32;
  localparam logic [31:0] DEF   = 32'h0000_00A5;
  localparam int          QUIET = 16;
  localparam int          TMO   = 200;
  localparam int          FLUSH = 2;
  localparam int          PLEN  = 220;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid, cfg_ready, cfg_force;
  logic [CW-1:0] cfg_lim_a, cfg_lim_b, cfg_lim_i;
  logic          raw_a, raw_b, raw_i;
  logic [CW-1:0] lim_a, lim_b, lim_i;
  logic          flt_rst, busy, apply_done, timeout_err;
`ifdef QEP_FILTER_STATS_EN
  logic [15:0]   edge_cnt_a, edge_cnt_b, edge_cnt_i;
`endif

  int errors = 0;
  int checks = 0;

  logic [2:0]  pat [0:PLEN-1];
  logic [31:0] mdl_a, mdl_b, mdl_i;

  always #5 clk = ~clk;

  qep_filter_sched #(
    .COUNTER_WIDTH  (CW),
    .DEFAULT_LIM    (DEF),
    .QUIET_CYCLES   (QUIET),
    .TIMEOUT_CYCLES (TMO),
    .FLUSH_CYCLES   (FLUSH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_force   (cfg_force),
    .cfg_lim_a   (cfg_lim_a),
    .cfg_lim_b   (cfg_lim_b),
    .cfg_lim_i   (cfg_lim_i),
    .raw_a       (raw_a),
    .raw_b       (raw_b),
    .raw_i       (raw_i),
    .lim_a       (lim_a),
    .lim_b       (lim_b),
    .lim_i       (lim_i),
    .flt_rst     (flt_rst),
    .busy        (busy),
    .apply_done  (apply_done),
    .timeout_err (timeout_err)
`ifdef QEP_FILTER_STATS_EN
    ,
    .edge_cnt_a  (edge_cnt_a),
    .edge_cnt_b  (edge_cnt_b),
    .edge_cnt_i  (edge_cnt_i)
`endif
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b required %0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_static(input logic [2:0] v);
    for (int k = 0; k < PLEN; k++) pat[k] = v;
  endtask

  // One write: handshake in cycle 0, then every output checked each cycle through apply_done.
  // With chain set, the next limit set (forced) is held on cfg_* for the whole sequence.
  task automatic run_txn(input logic [31:0] na, input logic [31:0] nb, input logic [31:0] ni,
                         input bit frc, input bit chain,
                         input logic [31:0] ca, input logic [31:0] cb, input logic [31:0] ci);
    int ap;
    int tcyc;
    int run;
    bit to;
    int idx;
    ap   = 1;
    tcyc = -1;
    to   = 0;
    if (!frc) begin
      run = 0;
      for (int k = 1; k <= TMO; k++) begin
        if (pat[k] != pat[k-1]) run = 0;
        else run++;
        if (k == TMO) begin
          to = 1; tcyc = k; ap = k + 1;
          break;
        end
        if (run >= QUIET) begin
          ap = k + 1;
          break;
        end
      end
    end

    cfg_valid = 1'b1;
    cfg_force = frc;
    cfg_lim_a = na;
    cfg_lim_b = nb;
    cfg_lim_i = ni;
    {raw_i, raw_b, raw_a} = pat[0];
    check1("ready_at_handshake", cfg_ready, 1'b1);
    check1("busy_at_handshake", busy, 1'b0);

    for (int n = 1; n <= ap + FLUSH + 1; n++) begin
      step();
      if (chain) begin
        cfg_valid = 1'b1; cfg_force = 1'b1;
        cfg_lim_a = ca; cfg_lim_b = cb; cfg_lim_i = ci;
      end else begin
        cfg_valid = 1'b0; cfg_force = 1'b0;
      end
      idx = (n < PLEN) ? n : PLEN - 1;
      {raw_i, raw_b, raw_a} = pat[idx];
      check1($sformatf("busy n=%0d ap=%0d", n, ap), busy, n <= ap + FLUSH);
      check1($sformatf("cfg_ready n=%0d ap=%0d", n, ap), cfg_ready, n > ap + FLUSH);
      check1($sformatf("flt_rst n=%0d ap=%0d", n, ap), flt_rst, (n >= ap + 1) && (n <= ap + FLUSH));
      check1($sformatf("apply_done n=%0d ap=%0d", n, ap), apply_done, n == ap + FLUSH + 1);
      check1($sformatf("timeout_err n=%0d ap=%0d", n, ap), timeout_err, to && (n == tcyc));
      check32($sformatf("lim_a n=%0d ap=%0d", n, ap), lim_a, (n >= ap + 1) ? na : mdl_a);
      check32($sformatf("lim_b n=%0d ap=%0d", n, ap), lim_b, (n >= ap + 1) ? nb : mdl_b);
      check32($sformatf("lim_i n=%0d ap=%0d", n, ap), lim_i, (n >= ap + 1) ? ni : mdl_i);
    end
    mdl_a = na; mdl_b = nb; mdl_i = ni;
  endtask

  initial begin
    logic [2:0] m;
    logic [2:0] cur;
    bit         frc;

    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_force = 1'b0;
    cfg_lim_a = '0; cfg_lim_b = '0; cfg_lim_i = '0;
    raw_a = 1'b0; raw_b = 1'b0; raw_i = 1'b0;
    mdl_a = DEF; mdl_b = DEF; mdl_i = DEF;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check32("rst lim_a", lim_a, DEF);
    check32("rst lim_b", lim_b, DEF);
    check32("rst lim_i", lim_i, DEF);
    check1("rst flt_rst", flt_rst, 1'b0);
    check1("rst busy", busy, 1'b0);
    check1("rst apply_done", apply_done, 1'b0);
    check1("rst timeout_err", timeout_err, 1'b0);
    check1("rst cfg_ready", cfg_ready, 1'b1);

    // Forced write 5/7/3
    fill_static(3'b000);
    run_txn(32'd5, 32'd7, 32'd3, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    step();

    // Static lines, quiet apply after 16 wait cycles
    fill_static(3'b000);
    run_txn(32'h1111, 32'h2222, 32'h3333, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();

    // raw_a toggling every 10 cycles: never quiet, timeout apply
    pat[0] = 3'b000;
    for (int k = 1; k < PLEN; k++) pat[k] = pat[k-1] ^ (((k % 10) == 0) ? 3'b001 : 3'b000);
    run_txn(32'hAAAA, 32'hBBBB, 32'hCCCC, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();

    // Edge on raw_i when the quiet count is at 15
    cur = {raw_i, raw_b, raw_a};
    for (int k = 0; k < PLEN; k++) pat[k] = (k >= 16) ? (cur ^ 3'b100) : cur;
    run_txn(32'd15, 32'd16, 32'd17, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();

    // Identical limits still run the full sequence; second set held through FLUSH
    fill_static({raw_i, raw_b, raw_a});
    run_txn(32'd15, 32'd16, 32'd17, 1'b0, 1'b1, 32'h77, 32'h88, 32'h99);
    run_txn(32'h77, 32'h88, 32'h99, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    step();

    // Randomised writes
    for (int t = 0; t < 12; t++) begin
      frc = ($urandom_range(0, 3) == 0);
      pat[0] = {raw_i, raw_b, raw_a};
      for (int k = 1; k < PLEN; k++) begin
        m = 3'b000;
        if ($urandom_range(0, 19) == 0) m = 3'b001 << $urandom_range(0, 2);
        pat[k] = pat[k-1] ^ m;
      end
      run_txn($urandom, $urandom, $urandom, frc, 1'b0, 32'd0, 32'd0, 32'd0);
      repeat ($urandom_range(1, 3)) step();
    end

    // Reset in the middle of a quiet wait drops the pending set
    fill_static({raw_i, raw_b, raw_a});
    cfg_valid = 1'b1; cfg_force = 1'b0;
    cfg_lim_a = 32'h5151; cfg_lim_b = 32'h5252; cfg_lim_i = 32'h5353;
    step();
    cfg_valid = 1'b0;
    repeat (5) step();
    check1("midq busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check32("midq rst lim_a", lim_a, DEF);
    check32("midq rst lim_b", lim_b, DEF);
    check32("midq rst lim_i", lim_i, DEF);
    check1("midq rst busy", busy, 1'b0);
    check1("midq rst flt_rst", flt_rst, 1'b0);
    mdl_a = DEF; mdl_b = DEF; mdl_i = DEF;
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step();
      check1($sformatf("post-rst apply_done n=%0d", n), apply_done, 1'b0);
      check1($sformatf("post-rst busy n=%0d", n), busy, 1'b0);
      check32($sformatf("post-rst lim_a n=%0d", n), lim_a, mdl_a);
    end

    // Writes still work after the interrupted sequence
    fill_static({raw_i, raw_b, raw_a});
    run_txn(32'h0F0F, 32'hF0F0, 32'h00FF, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qep_filter_sched.md
Name: qep_filter_sched

Overview:
- Sequences limit updates for the three QEP glitch filters (A, B, Index), each of which rejects transitions spaced closer than its cnt_lim + 1 cycles.
- Host software writes new limits through a valid/ready port. The block waits until the raw encoder lines are quiet, or until a timeout expires, then applies all three limits atomically and pulses a reset into the filters.
- Sits between the motor-control register file and the filter instances inside the QEP core.

Parameters:
- COUNTER_WIDTH, 32: width of each filter limit.
- DEFAULT_LIM, 0: value driven on lim_a/lim_b/lim_i after reset.
- QUIET_CYCLES, 16: consecutive edge-free cycles required before an apply. A value of 0 is treated as 1.
- TIMEOUT_CYCLES, 65536: maximum cycles spent waiting for quiet.
- FLUSH_CYCLES, 2: number of cycles flt_rst is held high.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_valid  in  1  new limit set offered
- cfg_ready  out  1  block accepts a limit set
- cfg_force  in  1  sampled with the handshake; skip the quiet wait
- cfg_lim_a  in  COUNTER_WIDTH  new limit, channel A
- cfg_lim_b  in  COUNTER_WIDTH  new limit, channel B
- cfg_lim_i  in  COUNTER_WIDTH  new limit, Index channel
- raw_a, raw_b, raw_i  in  1 each  synchronised, unfiltered encoder lines
- lim_a, lim_b, lim_i  out  COUNTER_WIDTH each  registered limits to the filters
- flt_rst  out  1  registered reset to the filter instances
- busy  out  1  high whenever state != IDLE
- apply_done  out  1  one-cycle pulse when the sequence completes
- timeout_err  out  1  one-cycle pulse when an apply was forced by timeout

Behaviour:
- Reset values (async on rst_n low):
  - lim_* = DEFAULT_LIM
  - flt_rst, busy, apply_done, timeout_err = 0
  - State = IDLE; all counters = 0; raw_*_z1 = 0
  - Any pending shadow limits are discarded.
- Edge detection: an edge is any raw_x != raw_x_z1 in a cycle. A raw line high out of reset registers as an edge in the first cycle.
- FSM states: IDLE, QUIESCE, APPLY, FLUSH.
- IDLE:
  - cfg_ready = 1.
  - On the handshake cycle T, latch cfg_lim_* into shadow registers.
  - If cfg_force = 1, go to APPLY; otherwise go to QUIESCE and clear the quiet and timeout counters.
- QUIESCE:
  - cfg_ready = 0.
  - Quiet counter clears on any edge and increments otherwise.
  - Timeout counter increments every cycle.
  - When the quiet counter reaches QUIET_CYCLES-1 in an edge-free cycle, go to APPLY.
  - When the timeout counter reaches TIMEOUT_CYCLES-1, go to APPLY and pulse timeout_err for one cycle.
  - If both conditions occur in the same cycle, timeout wins.
- APPLY:
  - Lasts one cycle.
  - At the end of that cycle, lim_* <= shadow, flt_rst <= 1, and the FSM moves to FLUSH.
- FLUSH:
  - flt_rst stays high for exactly FLUSH_CYCLES cycles, then the FSM returns to IDLE.
  - apply_done pulses in the first IDLE cycle; cfg_ready is high in that same cycle.
- Forced-write latency: handshake at T, APPLY at T+1, lim_* and flt_rst visible at T+2, flt_rst high through T+1+FLUSH_CYCLES, apply_done at T+2+FLUSH_CYCLES.
- Quiet-write latency: APPLY is reached QUIET_CYCLES cycles after entering QUIESCE when the raw lines are static.
- cfg_valid while busy: cfg_ready stays low and the request is held off (standard valid/ready). The request is not dropped.
- Identical limits still run the full sequence.
- lim_* never change outside the APPLY→FLUSH edge. All three limits update in the same cycle.
- Counters are sized to hold TIMEOUT_CYCLES-1 and never wrap inside a sequence.

Optional Feature:
- Macro: QEP_FILTER_STATS_EN
- With the macro defined:
  - Adds output ports edge_cnt_a, edge_cnt_b, edge_cnt_i, each 16 bits.
  - Each is a saturating count of raw edges on its line, saturating at 0xFFFF.
  - All three clear in the APPLY cycle.
  - Reset value 0.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package qep_pkg holds:
  - The state enum (IDLE/QUIESCE/APPLY/FLUSH).
  - Channel index constants CH_A=0, CH_B=1, CH_I=2.
  - The default COUNTER_WIDTH.
- Sub-module qep_quiet_detect:
  - Contains the raw line registers, 3-line edge detection and the quiet counter.
  - Outputs any_edge and quiet_reached.
  - Instantiated once.

Test Plan:
- Reset, then force write of a=5, b=7, i=3 at T → lim_*=5/7/3 at T+2; flt_rst high for T+2..T+3; apply_done at T+4; timeout_err stays 0.
- Raw lines static, non-forced write → APPLY entered exactly 16 cycles after QUIESCE; lims update one cycle later.
- raw_a toggling every 10 cycles with TIMEOUT_CYCLES=200 → no quiet apply; timeout_err pulses at cycle 199 of QUIESCE; lims still applied.
- An edge on raw_i at quiet count 15 → counter clears; apply occurs 16 edge-free cycles later.
- cfg_valid held during FLUSH with a new set → cfg_ready is 0 until the IDLE cycle; the second set is accepted there and applied via a second full sequence.
- rst_n asserted mid-QUIESCE → lim_* = DEFAULT_LIM immediately, busy=0, shadow dropped; no apply_done after release.
